dm_resp: RTL

- Responder end of the MEM-stage data-memory interface.
- Accepts one word-addressed load/store request from the initiator (address, 4-bit byte enable, store data, write flag).
- Performs the access after a fixed, parameterised latency and returns one response pulse.
- Replaces the single-cycle data memory when memory is modelled as a multi-cycle slave; the pipeline stalls on it through req_ready/resp_valid.

---
 rtl/dm_resp_pkg.sv | 29 ++
 rtl/dm_if.sv | 24 ++
 rtl/dm_bank.sv | 35 +++
 rtl/dm_resp.sv | 108 ++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM encoding,
// legal byte-enable patterns and the captured request record.
package dm_resp_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dm_req_t;

    // Only naturally aligned byte, half and word accesses are accepted.
    function automatic logic be_legal(input logic [3:0] be);
        return be inside {BE_B0, BE_B1, BE_B2, BE_B3, BE_HLO, BE_HHI, BE_WORD};
    endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response bundle between the MEM-stage initiator and the data-memory responder.
interface dm_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dm_bank.sv
// Word-organised storage with per-lane write enables, combinational read and
// synchronous clear of every word on reset.
module dm_bank #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned Words = 1 << ADDR_WIDTH;

    logic [31:0] mem [Words];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Words; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (we[l]) begin
                    mem[addr][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    // Read returns the pre-edge word, so a load never sees a same-edge store.
    assign rdata = mem[addr];

endmodule

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: accepts one request, performs it LATENCY
// cycles later and returns a single-cycle response pulse.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    dm_if.slave  bus
);

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dm_req_t     req_q, req_d, live, acc;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        accept, do_access, acc_err;
    logic [31:0] offset, bank_rdata;
    logic [3:0]  bank_we;

    assign bus.req_ready  = (state_q == IDLE) || (state_q == RESP);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign accept = bus.req_valid && bus.req_ready;
    assign live   = '{write: bus.req_write, addr: bus.req_addr, be: bus.req_be,
                      wdata: bus.req_wdata};

    // With LATENCY==1 the access happens on the acceptance edge from live inputs.
    assign acc       = (state_q == WAIT) ? req_q : live;
    assign do_access = ((state_q == WAIT) && (cnt_q == 4'd1)) || (accept && (LATENCY == 1));

    // Unsigned subtraction: addresses below the base wrap and land out of range.
    assign offset  = acc.addr - BASE_ADDR;
    assign acc_err = ((offset >> (ADDR_WIDTH + 2)) != 32'd0) || !be_legal(acc.be);
    assign bank_we = (do_access && !acc_err && acc.write) ? acc.be : 4'b0000;

    dm_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .we   (bank_we),
        .addr (offset[ADDR_WIDTH+1:2]),
        .wdata(acc.wdata),
        .rdata(bank_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    req_d   = live;
                    cnt_d   = CntInit;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            resp_valid_d = 1'b1;
            resp_err_d   = acc_err;
            resp_rdata_d = (!acc_err && !acc.write) ? bank_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule
